mem_lsq_wb: RTL and testbench
=============================

// Module: mem_lsq_wb
// PURPOSE
//  In-order memory-stage retire queue: replaces the single-register MEM stage.
//  Holds up to DEPTH in-flight instructions, pairs each load with its in-order dcache
//  response, applies byte/half/word/LWL/LWR alignment and merge, then hands one entry
//  per cycle to WB. Sits between the EX/dcache-request stage and WB; drives WB register
//  fields and the bypass network.
// PARAMETERS
//  DEPTH    4   queue entries (power of 2, >=2); also max outstanding dcache loads
//  MEMOP_W  10  one-hot memop: [0]LB [1]LBU [2]LH [3]LHU [4]LW [8]LWL [9]LWR, others ignored
// PORTS
//  clk         in   1        clock
//  rst_n       in   1        synchronous active-low reset
//  in_valid_i  in   1        EX presents an instruction
//  in_ready_o  out  1        queue not full (count<DEPTH); transfer = valid&ready
//  in_inst_i   in   32       instruction word
//  in_pc_i     in   32       PC
//  in_memop_i  in   MEMOP_W  one-hot memop
//  in_load_i   in   1        load: entry waits for a dcache response
//  in_addrlo_i in   2        byte offset of load address
//  in_waddr_i  in   5        GPR destination (0 = none)
//  in_wdata_i  in   32       ALU result, or old rt value for LWL/LWR merge
//  in_wren_i   in   4        byte write enables to GPR
//  in_c0ren_i  in   1        select in_c0data_i as result (non-load only)
//  in_c0data_i in   32       CP0 read data
//  flush_i     in   1        exception/eret flush
//  dc_rvalid_i in   1        dcache load response valid (strictly in issue order)
//  dc_rdata_i  in   32       dcache response word
//  wb_valid_o  out  1        head entry complete and presented to WB
//  wb_ready_i  in   1        WB accepts; retire = wb_valid_o&wb_ready_i
//  wb_inst_o / wb_pc_o / wb_waddr_o / wb_wdata_o / wb_wren_o  out  32/32/5/32/4  head fields
//  bp_wdata_o  out  32       youngest entry result for bypass (= in_wdata_i if non-load)
//  bp_nofwd_o  out  1        youngest entry is an incomplete load (no forward)
//  stall_o     out  1        ~in_ready_o | (queue head is load awaiting data)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): head/tail ptrs=0, count=0, drop_cnt=0, all entries
//    invalid; wb_valid_o=0, wb_* fields=0, bp_nofwd_o=0, bp_wdata_o=0, stall_o=0.
//  - Entry states: EMPTY -> WAIT (load enqueued) -> DONE (response bound) -> EMPTY (retire);
//    non-loads enqueue directly DONE with result = c0ren ? c0data : wdata.
//  - Responses bind to oldest WAIT entry (separate resp ptr); latency min 1 cycle: data
//    arriving cycle N makes wb_valid_o=1 in N+1 if that entry is head.
//  - Alignment (a=addrlo, d=rdata): LB/LBU byte a sign/zero-extended; LH/LHU half a[1];
//    LW d; LWL a=0..3 -> {d[7:0],24'b0},{d[15:0],16'b0},{d[23:0],8'b0},d, wren 1000/1100/1110/1111;
//    LWR a=0..3 -> d,{8'b0,d[31:8]},{16'b0,d[31:16]},{24'b0,d[31:24]}, wren 1111/0111/0011/0001.
//    LWL/LWR merge: wb_wdata byte i = wren[i] ? result : in_wdata_i byte i.
//  - Full: in_ready_o=0 when count==DEPTH; simultaneous retire+enqueue at full is NOT allowed
//    (ready is registered-count based). Enqueue and retire same cycle otherwise: count unchanged.
//  - Pointer wrap at DEPTH modulo; empty: wb_valid_o=0, bp_nofwd_o=0.
//  - flush_i: all entries invalidated next cycle, count=0, in_valid_i that cycle ignored;
//    drop_cnt += number of WAIT entries; subsequent dc_rvalid_i while drop_cnt>0 decrement
//    it and are discarded. Flush + response same cycle: response counted against drop path
//    if its target was flushed. drop_cnt width clog2(DEPTH)+1; in_ready_o=0 while
//    count+drop_cnt==DEPTH.
//  - dc_rvalid_i with no WAIT entry and drop_cnt=0: ignored (assertion in sim).
// CONFIGURATION
//  MEM_LSQ_ALIGN_EXC_EN defined: LH/LHU with a[0]=1 or LW with a!=0 enqueue DONE with
//    wren=0, waddr=0, extra out wb_adel_o=1 (1 bit), and do not consume a dcache response.
//  Undefined: no wb_adel_o port; misaligned loads wait for data, low address bits truncated.
// TESTING
//  LB a=3, rdata 0x80FF_1234 -> wb_wdata 0xFFFF_FF80, wren 1111, one cycle after rvalid.
//  LWL a=1, rdata 0xAABBCCDD, old rt 0x11223344 -> wb_wdata 0xCCDD3344, wren 1100.
//  DEPTH=4: 4 loads no response -> in_ready_o=0, stall_o=1; 4 responses -> in-order retire.
//  2 loads WAIT, flush_i, 2 late rvalid then new LW rdata 0x5 -> only 0x5 retires.
//  wb_ready_i=0 for 3 cycles with head DONE -> wb_* stable, no retire, no data loss.
//  ALIGN_EXC_EN: LW a=2 -> wb_adel_o=1, wren 0000, no response consumed.

Source files
------------

// File: rtl/mem_lsq_wb.sv
// In-order memory-stage retire queue. Holds up to DEPTH instructions between EX and WB,
// binds in-order dcache load responses to the oldest waiting load, applies load
// alignment/LWL/LWR merge and presents the head entry to WB. Loads flushed while still
// waiting are tracked in drop_q so their late responses are discarded.
// Optional feature macro: MEM_LSQ_ALIGN_EXC_EN (misaligned LH/LHU/LW raise wb_adel_o).
module mem_lsq_wb #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MEMOP_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [31:0]        in_inst_i,
  input  logic [31:0]        in_pc_i,
  input  logic [MEMOP_W-1:0] in_memop_i,
  input  logic               in_load_i,
  input  logic [1:0]         in_addrlo_i,
  input  logic [4:0]         in_waddr_i,
  input  logic [31:0]        in_wdata_i,
  input  logic [3:0]         in_wren_i,
  input  logic               in_c0ren_i,
  input  logic [31:0]        in_c0data_i,
  input  logic               flush_i,
  input  logic               dc_rvalid_i,
  input  logic [31:0]        dc_rdata_i,
  output logic               wb_valid_o,
  input  logic               wb_ready_i,
  output logic [31:0]        wb_inst_o,
  output logic [31:0]        wb_pc_o,
  output logic [4:0]         wb_waddr_o,
  output logic [31:0]        wb_wdata_o,
  output logic [3:0]         wb_wren_o,
  output logic [31:0]        bp_wdata_o,
  output logic               bp_nofwd_o,
  output logic               stall_o
`ifdef MEM_LSQ_ALIGN_EXC_EN
  ,
  output logic               wb_adel_o
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned SumW = CntW + 1;
  localparam logic [SumW-1:0] DepthS = SumW'(DEPTH);

  typedef enum logic [1:0] {StEmpty, StWait, StDone} ent_st_e;

  // Compressed memop: [0]LB [1]LBU [2]LH [3]LHU [4]LW [5]LWL [6]LWR
  ent_st_e     st_q     [DEPTH];
  logic [31:0] inst_q   [DEPTH];
  logic [31:0] pc_q     [DEPTH];
  logic [31:0] res_q    [DEPTH];  // old rt while waiting, final result once done
  logic [4:0]  waddr_q  [DEPTH];
  logic [3:0]  wren_q   [DEPTH];
  logic [6:0]  op_q     [DEPTH];
  logic [1:0]  addrlo_q [DEPTH];
`ifdef MEM_LSQ_ALIGN_EXC_EN
  logic        adel_q   [DEPTH];
`endif

  logic [PtrW-1:0] head_q, tail_q, young_idx, wait_idx, scan_idx;
  logic [CntW-1:0] count_q, count_d, drop_q, drop_d, n_wait;
  logic            wait_found, head_done, head_wait;
  logic            enq, ret, rsp_drop, rsp_bind;
  logic [6:0]      enq_op;
  logic [3:0]      enq_wren;
  logic [4:0]      enq_waddr;
  logic [31:0]     enq_res, bind_res;
  logic            enq_adel;
  ent_st_e         enq_st;
  logic            unused_memop;

  assign unused_memop = ^in_memop_i[7:5];

  function automatic logic [31:0] align_load(logic [6:0] op, logic [1:0] a, logic [31:0] d,
                                             logic [31:0] old, logic [3:0] wren);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = d[{a, 3'b000} +: 8];
    h = a[1] ? d[31:16] : d[15:0];
    r = d;
    if (op[0])      r = {{24{b[7]}}, b};
    else if (op[1]) r = {24'h0, b};
    else if (op[2]) r = {{16{h[15]}}, h};
    else if (op[3]) r = {16'h0, h};
    else if (op[4]) r = d;
    else if (op[5]) r = d << {~a, 3'b000};
    else if (op[6]) r = d >> {a, 3'b000};
    // Partial-word loads keep the unwritten bytes of the old register value
    if (op[5] || op[6]) begin
      for (int i = 0; i < 4; i++) begin
        if (!wren[i]) r[8*i +: 8] = old[8*i +: 8];
      end
    end
    return r;
  endfunction

  // Decode the incoming instruction into its entry fields
  always_comb begin
    enq_op    = {in_memop_i[9], in_memop_i[8], in_memop_i[4:0]};
    enq_wren  = in_wren_i;
    enq_waddr = in_waddr_i;
    enq_adel  = 1'b0;
    if (in_load_i && in_memop_i[8]) enq_wren = 4'hF << ~in_addrlo_i;
    else if (in_load_i && in_memop_i[9]) enq_wren = 4'hF >> in_addrlo_i;
`ifdef MEM_LSQ_ALIGN_EXC_EN
    enq_adel = in_load_i &&
               (((in_memop_i[2] || in_memop_i[3]) && in_addrlo_i[0]) ||
                (in_memop_i[4] && (in_addrlo_i != 2'b00)));
    if (enq_adel) begin
      enq_wren  = 4'h0;
      enq_waddr = 5'd0;
    end
`endif
    enq_st  = (in_load_i && !enq_adel) ? StWait : StDone;
    enq_res = (!in_load_i && in_c0ren_i) ? in_c0data_i : in_wdata_i;
  end

  // Locate the oldest waiting load (response target) and count waiting loads
  always_comb begin
    wait_found = 1'b0;
    wait_idx   = head_q;
    scan_idx   = head_q;
    n_wait     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PtrW'(i);
      if (st_q[scan_idx] == StWait) begin
        n_wait = n_wait + CntW'(1);
        if (!wait_found) begin
          wait_found = 1'b1;
          wait_idx   = scan_idx;
        end
      end
    end
  end

  // Handshakes, response routing and occupancy next-state
  always_comb begin
    in_ready_o = ({1'b0, count_q} + {1'b0, drop_q}) < DepthS;
    head_done  = (st_q[head_q] == StDone);
    head_wait  = (st_q[head_q] == StWait);
    enq        = in_valid_i && in_ready_o && !flush_i;
    ret        = head_done && wb_ready_i && !flush_i;
    rsp_drop   = dc_rvalid_i && (drop_q != '0);
    rsp_bind   = dc_rvalid_i && (drop_q == '0) && wait_found && !flush_i;
    // On flush a same-cycle response belongs to an already-flushed load if any exists
    if (flush_i) begin
      drop_d = drop_q + n_wait - CntW'(dc_rvalid_i && ((drop_q != '0) || wait_found));
    end else begin
      drop_d = drop_q - CntW'(rsp_drop);
    end
    count_d  = count_q + CntW'(enq) - CntW'(ret);
    bind_res = align_load(op_q[wait_idx], addrlo_q[wait_idx], dc_rdata_i, res_q[wait_idx],
                          wren_q[wait_idx]);
  end

  // Head fields to WB and youngest-entry bypass
  always_comb begin
    young_idx  = tail_q - PtrW'(1);
    wb_valid_o = head_done;
    wb_inst_o  = head_done ? inst_q[head_q]  : '0;
    wb_pc_o    = head_done ? pc_q[head_q]    : '0;
    wb_waddr_o = head_done ? waddr_q[head_q] : '0;
    wb_wdata_o = head_done ? res_q[head_q]   : '0;
    wb_wren_o  = head_done ? wren_q[head_q]  : '0;
`ifdef MEM_LSQ_ALIGN_EXC_EN
    wb_adel_o  = head_done && adel_q[head_q];
`endif
    bp_nofwd_o = (count_q != '0) && (st_q[young_idx] == StWait);
    bp_wdata_o = (count_q != '0) ? res_q[young_idx] : '0;
    stall_o    = !in_ready_o || head_wait;
  end

  // Pointers, occupancy, drop counter and per-entry state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
      for (int i = 0; i < DEPTH; i++) st_q[i] <= StEmpty;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= drop_d;
      for (int i = 0; i < DEPTH; i++) st_q[i] <= StEmpty;
    end else begin
      if (enq) begin
        st_q[tail_q] <= enq_st;
        tail_q       <= tail_q + PtrW'(1);
      end
      if (rsp_bind) st_q[wait_idx] <= StDone;
      if (ret) begin
        st_q[head_q] <= StEmpty;
        head_q       <= head_q + PtrW'(1);
      end
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  // Entry payload; validity is carried by st_q so no reset is needed here
  always_ff @(posedge clk) begin
    if (enq) begin
      inst_q[tail_q]   <= in_inst_i;
      pc_q[tail_q]     <= in_pc_i;
      res_q[tail_q]    <= enq_res;
      waddr_q[tail_q]  <= enq_waddr;
      wren_q[tail_q]   <= enq_wren;
      op_q[tail_q]     <= enq_op;
      addrlo_q[tail_q] <= in_addrlo_i;
`ifdef MEM_LSQ_ALIGN_EXC_EN
      adel_q[tail_q]   <= enq_adel;
`endif
    end
    if (rsp_bind) res_q[wait_idx] <= bind_res;
  end

`ifndef SYNTHESIS
  // A response with no waiting load and nothing to drop means dcache and queue disagree
  a_stray_rsp : assert property (@(posedge clk) disable iff (!rst_n)
                                 dc_rvalid_i |-> ((drop_q != '0) || wait_found));
`endif

endmodule

// File: tb/tb_mem_lsq_wb.sv
// Randomized bench for mem_lsq_wb with a queue-based reference model and directed cases.
module tb_mem_lsq_wb;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_i, in_load_i, in_c0ren_i, flush_i, dc_rvalid_i, wb_ready_i;
  logic [31:0] in_inst_i, in_pc_i, in_wdata_i, in_c0data_i, dc_rdata_i;
  logic [9:0]  in_memop_i;
  logic [1:0]  in_addrlo_i;
  logic [4:0]  in_waddr_i;
  logic [3:0]  in_wren_i;
  logic        in_ready_o, wb_valid_o, bp_nofwd_o, stall_o;
  logic [31:0] wb_inst_o, wb_pc_o, wb_wdata_o, bp_wdata_o;
  logic [4:0]  wb_waddr_o;
  logic [3:0]  wb_wren_o;
`ifdef MEM_LSQ_ALIGN_EXC_EN
  logic        wb_adel_o;
`endif

  always #5 clk = ~clk;

  mem_lsq_wb #(.DEPTH(DEPTH), .MEMOP_W(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_inst_i(in_inst_i), .in_pc_i(in_pc_i),
    .in_memop_i(in_memop_i), .in_load_i(in_load_i), .in_addrlo_i(in_addrlo_i),
    .in_waddr_i(in_waddr_i), .in_wdata_i(in_wdata_i), .in_wren_i(in_wren_i),
    .in_c0ren_i(in_c0ren_i), .in_c0data_i(in_c0data_i), .flush_i(flush_i),
    .dc_rvalid_i(dc_rvalid_i), .dc_rdata_i(dc_rdata_i), .wb_valid_o(wb_valid_o),
    .wb_ready_i(wb_ready_i), .wb_inst_o(wb_inst_o), .wb_pc_o(wb_pc_o), .wb_waddr_o(wb_waddr_o),
    .wb_wdata_o(wb_wdata_o), .wb_wren_o(wb_wren_o), .bp_wdata_o(bp_wdata_o),
    .bp_nofwd_o(bp_nofwd_o), .stall_o(stall_o)
`ifdef MEM_LSQ_ALIGN_EXC_EN
    , .wb_adel_o(wb_adel_o)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] inst, pc, res, old;
    logic [4:0]  waddr;
    logic [3:0]  wren;
    logic [9:0]  op;
    logic [1:0]  a;
    bit          waiting;
    bit          adel;
  } ent_t;

  ent_t q[$];
  int   m_drop = 0;

  function automatic logic [3:0] m_wren(logic [9:0] op, logic [1:0] a, logic [3:0] w);
    if (op[8]) begin
      case (a)
        2'd0: return 4'b1000;
        2'd1: return 4'b1100;
        2'd2: return 4'b1110;
        default: return 4'b1111;
      endcase
    end
    if (op[9]) begin
      case (a)
        2'd0: return 4'b1111;
        2'd1: return 4'b0111;
        2'd2: return 4'b0011;
        default: return 4'b0001;
      endcase
    end
    return w;
  endfunction

  function automatic logic [31:0] m_result(logic [9:0] op, logic [1:0] a, logic [31:0] d,
                                           logic [31:0] old);
    logic [7:0]  by [4];
    logic [15:0] h;
    logic [31:0] raw;
    logic [3:0]  we;
    for (int i = 0; i < 4; i++) by[i] = d[8*i +: 8];
    h   = a[1] ? d[31:16] : d[15:0];
    raw = d;
    if (op[0]) raw = 32'($signed(by[a]));
    else if (op[1]) raw = {24'h0, by[a]};
    else if (op[2]) raw = 32'($signed(h));
    else if (op[3]) raw = {16'h0, h};
    else if (op[8]) begin
      case (a)
        2'd0: raw = {d[7:0], 24'h0};
        2'd1: raw = {d[15:0], 16'h0};
        2'd2: raw = {d[23:0], 8'h0};
        default: raw = d;
      endcase
    end else if (op[9]) begin
      case (a)
        2'd0: raw = d;
        2'd1: raw = {8'h0, d[31:8]};
        2'd2: raw = {16'h0, d[31:16]};
        default: raw = {24'h0, d[31:24]};
      endcase
    end
    if (op[8] || op[9]) begin
      we = m_wren(op, a, 4'h0);
      for (int i = 0; i < 4; i++) if (!we[i]) raw[8*i +: 8] = old[8*i +: 8];
    end
    return raw;
  endfunction

  function automatic bit m_adel(bit load, logic [9:0] op, logic [1:0] a);
`ifdef MEM_LSQ_ALIGN_EXC_EN
    return load && (((op[2] || op[3]) && a[0]) || (op[4] && a != 2'd0));
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_any_wait();
    foreach (q[i]) if (q[i].waiting) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin : model
    bit   rdy, ret, bound;
    int   nw;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      m_drop = 0;
    end else begin
      rdy = (q.size() + m_drop) < DEPTH;
      ret = (q.size() > 0) && !q[0].waiting && wb_ready_i;
      if (flush_i) begin
        nw = 0;
        foreach (q[i]) if (q[i].waiting) nw++;
        m_drop = m_drop + nw;
        if (dc_rvalid_i && m_drop > 0) m_drop--;
        q.delete();
      end else begin
        if (dc_rvalid_i) begin
          if (m_drop > 0) m_drop--;
          else begin
            bound = 1'b0;
            for (int i = 0; i < q.size(); i++) begin
              if (!bound && q[i].waiting) begin
                q[i].res     = m_result(q[i].op, q[i].a, dc_rdata_i, q[i].old);
                q[i].waiting = 1'b0;
                bound        = 1'b1;
              end
            end
          end
        end
        if (ret) void'(q.pop_front());
        if (in_valid_i && rdy) begin
          e.inst    = in_inst_i;
          e.pc      = in_pc_i;
          e.op      = in_memop_i;
          e.a       = in_addrlo_i;
          e.old     = in_wdata_i;
          e.adel    = m_adel(in_load_i, in_memop_i, in_addrlo_i);
          e.waiting = in_load_i && !e.adel;
          e.res     = (!in_load_i && in_c0ren_i) ? in_c0data_i : in_wdata_i;
          e.waddr   = e.adel ? 5'd0 : in_waddr_i;
          e.wren    = e.adel ? 4'h0 : (in_load_i ? m_wren(in_memop_i, in_addrlo_i, in_wren_i)
                                                 : in_wren_i);
          q.push_back(e);
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin : compare
    bit er, ev, hw, yw;
    if (rst_n !== 1'bx) begin
      er = (q.size() + m_drop) < DEPTH;
      ev = 1'b0;
      hw = 1'b0;
      yw = 1'b0;
      if (q.size() > 0) begin
        ev = !q[0].waiting;
        hw = q[0].waiting;
        yw = q[q.size()-1].waiting;
      end
      chk("in_ready", in_ready_o, er);
      chk("wb_valid", wb_valid_o, ev);
      chk("stall", stall_o, !er || hw);
      chk("bp_nofwd", bp_nofwd_o, yw);
      if (q.size() == 0) chk("bp_wdata_empty", bp_wdata_o, 32'h0);
      else if (!yw && !q[q.size()-1].adel) chk("bp_wdata", bp_wdata_o, q[q.size()-1].res);
      if (ev) begin
        chk("wb_inst", wb_inst_o, q[0].inst);
        chk("wb_pc", wb_pc_o, q[0].pc);
        chk("wb_waddr", wb_waddr_o, q[0].waddr);
        chk("wb_wren", wb_wren_o, q[0].wren);
        if (!q[0].adel) chk("wb_wdata", wb_wdata_o, q[0].res);
`ifdef MEM_LSQ_ALIGN_EXC_EN
        chk("wb_adel", wb_adel_o, q[0].adel);
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid_i = 0; in_load_i = 0; in_c0ren_i = 0; flush_i = 0; dc_rvalid_i = 0;
    in_inst_i = 0; in_pc_i = 0; in_wdata_i = 0; in_c0data_i = 0; dc_rdata_i = 0;
    in_memop_i = 0; in_addrlo_i = 0; in_waddr_i = 0; in_wren_i = 0;
  endtask

  task automatic put(input bit load, input logic [9:0] op, input logic [1:0] a,
                     input logic [4:0] waddr, input logic [31:0] wdata, input logic [3:0] wren);
    in_valid_i = 1; in_load_i = load; in_memop_i = op; in_addrlo_i = a; in_waddr_i = waddr;
    in_wdata_i = wdata; in_wren_i = wren; in_inst_i = $urandom; in_pc_i = $urandom;
    in_c0ren_i = 0;
  endtask

  task automatic do_reset();
    idle();
    wb_ready_i = 0;
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  int ops[7] = '{0, 1, 2, 3, 4, 8, 9};
  int rdy_pct;

  initial begin
    rst_n = 1'bx;
    idle();
    wb_ready_i = 0;
    #1;
    do_reset();
    // Reset state, literal
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_wb_wdata", wb_wdata_o, 0);
    chk("rst_ready", in_ready_o, 1);
    chk("rst_stall", stall_o, 0);
    chk("rst_bp_nofwd", bp_nofwd_o, 0);
    chk("rst_bp_wdata", bp_wdata_o, 0);

    // Pin the model's alignment rules to hand-computed values
    chk("pin_lb", m_result(10'h001, 2'd3, 32'h80FF_1234, 32'h0), 32'hFFFF_FF80);
    chk("pin_lwl", m_result(10'h100, 2'd1, 32'hAABB_CCDD, 32'h1122_3344), 32'hCCDD_3344);
    chk("pin_lwl_wren", m_wren(10'h100, 2'd1, 4'h0), 4'b1100);
    chk("pin_lwr", m_result(10'h200, 2'd2, 32'hAABB_CCDD, 32'h1122_3344), 32'h1122_AABB);

    // LB a=3
    put(1, 10'h001, 2'd3, 5'd5, 32'h0, 4'hF);
    tick();
    idle();
    chk("lb_wait_valid", wb_valid_o, 0);
    chk("lb_wait_stall", stall_o, 1);
    dc_rvalid_i = 1; dc_rdata_i = 32'h80FF_1234;
    tick();
    idle();
    chk("lb_valid", wb_valid_o, 1);
    chk("lb_wdata", wb_wdata_o, 32'hFFFF_FF80);
    chk("lb_wren", wb_wren_o, 4'hF);
    wb_ready_i = 1;
    tick();
    chk("lb_retired", wb_valid_o, 0);

    // LWL a=1 merge
    wb_ready_i = 0;
    put(1, 10'h100, 2'd1, 5'd6, 32'h1122_3344, 4'h0);
    tick();
    idle();
    dc_rvalid_i = 1; dc_rdata_i = 32'hAABB_CCDD;
    tick();
    idle();
    chk("lwl_wdata", wb_wdata_o, 32'hCCDD_3344);
    chk("lwl_wren", wb_wren_o, 4'b1100);
    wb_ready_i = 1;
    tick();

    // Fill with four loads, then four in-order responses
    wb_ready_i = 0;
    for (int i = 0; i < 4; i++) begin
      put(1, 10'h010, 2'd0, 5'(i + 1), 32'h0, 4'hF);
      tick();
    end
    idle();
    chk("full_ready", in_ready_o, 0);
    chk("full_stall", stall_o, 1);
    wb_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      dc_rvalid_i = 1; dc_rdata_i = 32'h100 + i;
      tick();
      chk("inorder_wdata", wb_wdata_o, 32'h100 + i);
    end
    idle();
    tick();
    chk("drain_valid", wb_valid_o, 0);
    chk("drain_ready", in_ready_o, 1);

    // Flush two waiting loads, drop their late responses
    for (int i = 0; i < 2; i++) begin
      put(1, 10'h010, 2'd0, 5'd3, 32'h0, 4'hF);
      tick();
    end
    idle();
    flush_i = 1;
    put(0, 10'h0, 2'd0, 5'd9, 32'h1234, 4'hF);
    tick();
    idle();
    chk("flush_valid", wb_valid_o, 0);
    chk("flush_nofwd", bp_nofwd_o, 0);
    for (int i = 0; i < 2; i++) begin
      dc_rvalid_i = 1; dc_rdata_i = 32'hDEAD_0000 + i;
      tick();
      chk("drop_valid", wb_valid_o, 0);
    end
    idle();
    put(1, 10'h010, 2'd0, 5'd4, 32'h0, 4'hF);
    tick();
    idle();
    dc_rvalid_i = 1; dc_rdata_i = 32'h5;
    tick();
    idle();
    chk("postflush_valid", wb_valid_o, 1);
    chk("postflush_wdata", wb_wdata_o, 32'h5);
    tick();
    chk("postflush_retired", wb_valid_o, 0);

    // WB back-pressure with a done head; then CP0 result select
    wb_ready_i = 0;
    put(0, 10'h0, 2'd0, 5'd7, 32'hCAFE_F00D, 4'hF);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid", wb_valid_o, 1);
      chk("hold_wdata", wb_wdata_o, 32'hCAFE_F00D);
    end
    wb_ready_i = 1;
    tick();
    chk("hold_retired", wb_valid_o, 0);
    put(0, 10'h0, 2'd0, 5'd8, 32'h1111_1111, 4'hF);
    in_c0ren_i = 1; in_c0data_i = 32'h1234_5678;
    tick();
    idle();
    chk("c0_wdata", wb_wdata_o, 32'h1234_5678);
    tick();

`ifdef MEM_LSQ_ALIGN_EXC_EN
    wb_ready_i = 0;
    put(1, 10'h010, 2'd2, 5'd9, 32'h0, 4'hF);
    tick();
    idle();
    chk("adel_valid", wb_valid_o, 1);
    chk("adel_flag", wb_adel_o, 1);
    chk("adel_wren", wb_wren_o, 4'h0);
    chk("adel_waddr", wb_waddr_o, 5'd0);
    chk("adel_stall", stall_o, 0);
    wb_ready_i = 1;
    tick();
`endif

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rdy_pct = ((c / 250) % 2 == 1) ? 25 : 85;
      in_valid_i  = ($urandom_range(0, 9) < 6);
      in_load_i   = $urandom_range(0, 1);
      in_memop_i  = in_load_i ? (10'h1 << ops[$urandom_range(0, 6)]) : 10'h0;
      in_addrlo_i = 2'($urandom_range(0, 3));
      in_waddr_i  = 5'($urandom_range(0, 31));
      in_wdata_i  = $urandom;
      in_wren_i   = 4'($urandom_range(0, 15));
      in_c0ren_i  = ($urandom_range(0, 4) == 0);
      in_c0data_i = $urandom;
      in_inst_i   = $urandom;
      in_pc_i     = $urandom;
      flush_i     = ($urandom_range(0, 39) == 0);
      dc_rvalid_i = (m_drop > 0 || m_any_wait()) && ($urandom_range(0, 1) == 1);
      dc_rdata_i  = $urandom;
      wb_ready_i  = ($urandom_range(0, 99) < rdy_pct);
      tick();
    end
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
